// File: rtl/fact_pkg.sv
// Shared definitions for the factorial arbiter: FSM state encodings and default widths.
// Latency: none (package only).
// Backpressure: none (package only).
package fact_pkg;

  localparam int FACT_DW = 32;
  localparam int FACT_NW = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_e;

endpackage

// File: rtl/fact_arbiter_rr_pick.sv
// Two-way round-robin pick: chooses which pending requester is granted next.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_pick (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       grant_vld,
  output logic       grant_idx
);

  // Single request wins outright; on contention the requester not served last wins.
  always_comb begin
    grant_vld = |req;
    grant_idx = 1'b0;
    case (req)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~last_owner;
      default: grant_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/fact_arbiter.sv
// Arbitrates two requesters onto one shared factorial unit; optional WAIT timeout under FACT_ARB_TIMEOUT_EN.
// Latency: grant edge, 1 cycle fact_go, k cycles WAIT, 1 cycle ack (IDLE revisited between requests).
// Backpressure: req held until ack; unit completion is awaited indefinitely unless the timeout is built in.
module fact_arbiter
  import fact_pkg::*;
#(
  parameter int DW      = FACT_DW,
  parameter int NW      = FACT_NW,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    req,
  input  logic [NW-1:0] n0,
  input  logic [NW-1:0] n1,
  output logic [1:0]    ack,
  output logic [DW-1:0] result,
  output logic          res_err,
  output logic          busy,
  output logic          owner,
  output logic          fact_go,
  output logic [NW-1:0] fact_n,
  input  logic          fact_done,
  input  logic          fact_err,
  input  logic [DW-1:0] fact_result,
  output logic          timeout
);

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_owner_q, last_owner_d;
  logic [NW-1:0] fact_n_q, fact_n_d;
  logic [DW-1:0] result_q, result_d;
  logic          res_err_q, res_err_d;
  logic          grant_vld;
  logic          grant_idx;

`ifdef FACT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          timeout_q, timeout_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  rr_pick u_rr_pick (
    .req        (req),
    .last_owner (last_owner_q),
    .grant_vld  (grant_vld),
    .grant_idx  (grant_idx)
  );

  // Next-state and datapath updates for the IDLE/ISSUE/WAIT/RESP sequence.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    fact_n_d     = fact_n_q;
    result_d     = result_q;
    res_err_d    = res_err_q;
`ifdef FACT_ARB_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
    timeout_d    = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          owner_d  = grant_idx;
          fact_n_d = grant_idx ? n1 : n0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
`ifdef FACT_ARB_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
        state_d = WAIT;
      end
      WAIT: begin
        // An error return outranks a simultaneous done.
        if (fact_done || fact_err) begin
          result_d  = fact_result;
          res_err_d = fact_err;
          state_d   = RESP;
        end
`ifdef FACT_ARB_TIMEOUT_EN
        else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
          result_d  = '0;
          res_err_d = 1'b1;
          timeout_d = 1'b1;
          state_d   = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        last_owner_d = owner_q;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset leaves requester 0 with first priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      fact_n_q     <= '0;
      result_q     <= '0;
      res_err_q    <= 1'b0;
`ifdef FACT_ARB_TIMEOUT_EN
      wait_cnt_q   <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      fact_n_q     <= fact_n_d;
      result_q     <= result_d;
      res_err_q    <= res_err_d;
`ifdef FACT_ARB_TIMEOUT_EN
      wait_cnt_q   <= wait_cnt_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  // Strobes decode straight from the state register so they are glitch-free per cycle.
  always_comb begin
    fact_go = (state_q == ISSUE);
    busy    = (state_q != IDLE);
    ack     = 2'b00;
    if (state_q == RESP) begin
      ack = owner_q ? 2'b10 : 2'b01;
    end
  end

  assign owner   = owner_q;
  assign fact_n  = fact_n_q;
  assign result  = result_q;
  assign res_err = res_err_q;
`ifdef FACT_ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fact_arbiter.sv
// Directed self-checking bench for fact_arbiter; exercises the timeout path when FACT_ARB_TIMEOUT_EN is defined.
// Latency: checks exact cycle placement of fact_go and ack.
// Backpressure: bench plays both requesters and the factorial unit.
module tb_fact_arbiter;

  localparam int DW = 32;
  localparam int NW = 4;
`ifdef FACT_ARB_TIMEOUT_EN
  localparam int K1 = 6;
`else
  localparam int K1 = 10;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req;
  logic [NW-1:0] n0, n1;
  logic [1:0]    ack;
  logic [DW-1:0] result;
  logic          res_err, busy, owner, fact_go;
  logic [NW-1:0] fact_n;
  logic          fact_done, fact_err;
  logic [DW-1:0] fact_result;
  logic          timeout;

  int passed = 0;
  int total  = 0;

  fact_arbiter #(.DW(DW), .NW(NW), .TIMEOUT(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .n0          (n0),
    .n1          (n1),
    .ack         (ack),
    .result      (result),
    .res_err     (res_err),
    .busy        (busy),
    .owner       (owner),
    .fact_go     (fact_go),
    .fact_n      (fact_n),
    .fact_done   (fact_done),
    .fact_err    (fact_err),
    .fact_result (fact_result),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One full transaction starting in IDLE with req already driven; unit answers in WAIT cycle k.
  task automatic run_txn(input string tag, input logic [1:0] exp_ack, input logic [NW-1:0] exp_n,
                         input int k, input logic d, input logic e, input logic [DW-1:0] r,
                         input logic [DW-1:0] exp_res, input logic exp_err, input logic drop);
    tick();
    check({tag, ".go"}, 64'(fact_go), 64'd1);
    check({tag, ".n"}, 64'(fact_n), 64'(exp_n));
    check({tag, ".owner"}, 64'(owner), 64'(exp_ack[1]));
    check({tag, ".busy"}, 64'(busy), 64'd1);
    tick();
    check({tag, ".go_once"}, 64'(fact_go), 64'd0);
    repeat (k - 1) tick();
    check({tag, ".no_early_ack"}, 64'(ack), 64'd0);
    fact_done   = d;
    fact_err    = e;
    fact_result = r;
    tick();
    fact_done = 1'b0;
    fact_err  = 1'b0;
    check({tag, ".ack"}, 64'(ack), 64'(exp_ack));
    check({tag, ".result"}, 64'(result), 64'(exp_res));
    check({tag, ".res_err"}, 64'(res_err), 64'(exp_err));
    check({tag, ".n_stable"}, 64'(fact_n), 64'(exp_n));
    if (drop) req = req & ~exp_ack;
    tick();
    check({tag, ".ack_pulse"}, 64'(ack), 64'd0);
    check({tag, ".idle"}, 64'(busy), 64'd0);
    check({tag, ".held"}, 64'(result), 64'(exp_res));
  endtask

  initial begin
    reset = 1'b1; req = 2'b00; n0 = '0; n1 = '0;
    fact_done = 1'b0; fact_err = 1'b0; fact_result = '0;
    tick(); tick();
    check("rst.ack", 64'(ack), 64'd0);
    check("rst.go", 64'(fact_go), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.res_err", 64'(res_err), 64'd0);
    check("rst.timeout", 64'(timeout), 64'd0);
    check("rst.result", 64'(result), 64'd0);
    check("rst.fact_n", 64'(fact_n), 64'd0);
    check("rst.owner", 64'(owner), 64'd0);
    reset = 1'b0;

    // Single requester 0, n=5, unit returns 120.
    req = 2'b01; n0 = 4'd5;
    run_txn("basic", 2'b01, 4'd5, K1, 1'b1, 1'b0, 32'd120, 32'd120, 1'b0, 1'b1);

    // Requester 1 with n=14, unit reports an error.
    req = 2'b10; n1 = 4'd14;
    run_txn("err", 2'b10, 4'd14, 3, 1'b0, 1'b1, 32'hBAD, 32'hBAD, 1'b1, 1'b1);

    // Both requesting continuously: alternate 0, 1, 0.
    req = 2'b11; n0 = 4'd3; n1 = 4'd4;
    run_txn("rr0", 2'b01, 4'd3, 2, 1'b1, 1'b0, 32'd6, 32'd6, 1'b0, 1'b0);
    run_txn("rr1", 2'b10, 4'd4, 4, 1'b1, 1'b0, 32'd24, 32'd24, 1'b0, 1'b0);
    run_txn("rr2", 2'b01, 4'd3, 1, 1'b1, 1'b0, 32'd6, 32'd6, 1'b0, 1'b0);
    req = 2'b00;

    // Done and error together: error wins.
    req = 2'b10; n1 = 4'd6;
    run_txn("both", 2'b10, 4'd6, 3, 1'b1, 1'b1, 32'd720, 32'd720, 1'b1, 1'b1);

    // Spurious done while IDLE is ignored.
    fact_done = 1'b1; fact_result = 32'd55;
    tick(); tick();
    check("spur.ack", 64'(ack), 64'd0);
    check("spur.busy", 64'(busy), 64'd0);
    check("spur.result", 64'(result), 64'd720);
    fact_done = 1'b0;

    // Reset in the middle of WAIT abandons the request.
    req = 2'b10; n1 = 4'd2;
    tick(); tick(); tick();
    check("rstw.in_wait", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstw.busy", 64'(busy), 64'd0);
    check("rstw.ack", 64'(ack), 64'd0);
    check("rstw.result", 64'(result), 64'd0);
    req = 2'b11; n0 = 4'd4; n1 = 4'd2;
    run_txn("rstw.next", 2'b01, 4'd4, 2, 1'b1, 1'b0, 32'd24, 32'd24, 1'b0, 1'b1);
    req = 2'b00;

`ifdef FACT_ARB_TIMEOUT_EN
    // Unit never answers: RESP after 8 WAIT cycles with error and sticky timeout.
    req = 2'b01; n0 = 4'd7;
    tick();
    check("to.go", 64'(fact_go), 64'd1);
    tick();
    repeat (7) tick();
    check("to.no_early_ack", 64'(ack), 64'd0);
    tick();
    check("to.ack", 64'(ack), 64'd1);
    check("to.res_err", 64'(res_err), 64'd1);
    check("to.result", 64'(result), 64'd0);
    check("to.flag", 64'(timeout), 64'd1);
    req = 2'b00;
    tick();
    check("to.sticky", 64'(timeout), 64'd1);
    req = 2'b01; n0 = 4'd1;
    run_txn("to.after", 2'b01, 4'd1, 2, 1'b1, 1'b0, 32'd1, 32'd1, 1'b0, 1'b1);
    check("to.sticky2", 64'(timeout), 64'd1);
`else
    check("timeout.tied", 64'(timeout), 64'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fact_arbiter.md
FACT_ARBITER -- requirements
Module: fact_arbiter

Interface
REQ-001 SHALL have parameter DW, default 32: result width.
REQ-002 SHALL have parameter NW, default 4: operand n width.
REQ-003 SHALL have parameter TIMEOUT, default 64: maximum WAIT cycles, used only under FACT_ARB_TIMEOUT_EN.
REQ-004 SHALL have port clk  input  1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-006 SHALL have port req  input  2: per-requester request levels; req[i] held high until ack[i].
REQ-007 SHALL have ports n0, n1  input  NW: operands of requesters 0 and 1.
REQ-008 SHALL have port ack  output  2: one-cycle pulse to the served requester.
REQ-009 SHALL have port result  output  DW: captured factorial result, valid while ack is high and held afterwards.
REQ-010 SHALL have port res_err  output  1: error or timeout for the served request, qualified by ack.
REQ-011 SHALL have ports busy  output  1 (state not IDLE) and owner  output  1 (index of the current or last granted requester).
REQ-012 SHALL have ports fact_go  output  1 and fact_n  output  NW: drive the shared factorial unit.
REQ-013 SHALL have ports fact_done  input  1, fact_err  input  1 and fact_result  input  DW: returned by the factorial unit.
REQ-014 SHALL have port timeout  output  1: sticky flag, cleared only by reset.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT and RESP.
REQ-016 In IDLE with any req bit high, the FSM SHALL grant a single requester, latch its operand into fact_n, set owner, and enter ISSUE on the next edge.
REQ-017 Grant selection SHALL be round-robin: if both req bits are high, grant goes to !last_owner; if one is high, grant goes to that one.
REQ-018 ISSUE SHALL assert fact_go for exactly one cycle and then enter WAIT.
REQ-019 fact_n SHALL stay stable from ISSUE through RESP.
REQ-020 In WAIT, fact_done or fact_err SHALL capture fact_result into result, capture fact_err into res_err, and move to RESP; if both are high, fact_err takes priority (res_err=1).
REQ-021 RESP SHALL pulse ack[owner] for one cycle, update last_owner to owner, and return to IDLE.
REQ-022 End-to-end latency SHALL be: grant edge, +1 cycle fact_go, WAIT for k cycles, +1 cycle ack.
REQ-023 A requester SHALL NOT be re-granted in the cycle its ack is high; IDLE is always visited for at least one cycle between requests.
REQ-024 A req withdrawn after grant SHALL be ignored; the sequence completes and ack still pulses.
REQ-025 fact_done or fact_err outside WAIT SHALL be ignored.
REQ-026 An illegal state encoding SHALL return the FSM to IDLE with all strobes low.

Reset
REQ-027 With reset high at an edge, the block SHALL set state=IDLE, ack=0, fact_go=0, busy=0, res_err=0, timeout=0, result=0, fact_n=0, owner=0 and last_owner=1, regardless of the current state; this gives requester 0 first priority.
REQ-028 Reset mid-WAIT SHALL abandon the request with no ack pulse.

Configuration
REQ-029 With macro FACT_ARB_TIMEOUT_EN defined, a WAIT counter SHALL clear on WAIT entry; on reaching TIMEOUT without done or err, the FSM SHALL enter RESP with result=0, res_err=1, and timeout set.
REQ-030 Without FACT_ARB_TIMEOUT_EN, WAIT SHALL be unbounded, no counter SHALL exist, and timeout SHALL be tied 0.

Structure
REQ-031 A shared package fact_pkg SHALL hold the state encodings (IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10, RESP=2'b11) and the default DW/NW constants.
REQ-032 The rr_pick sub-module SHALL compute the round-robin grant combinationally from req and last_owner; all other logic SHALL stay in fact_arbiter.

Verification
REQ-033 The bench SHALL cover: reset, req=2'b01, n0=5, model done after 10 cycles with 120 -> fact_go pulse with fact_n=5, ack=2'b01, result=120, res_err=0.
REQ-034 The bench SHALL cover: req=2'b11 held with n0=3 and n1=4 -> grants in order 0, 1, 0, ..., results 6 and 24, and each ack on the correct requester.
REQ-035 The bench SHALL cover: n1=14 with the model returning fact_err -> ack=2'b10, res_err=1; next request served normally.
REQ-036 The bench SHALL cover: reset asserted during WAIT -> no ack, busy=0 on the next cycle; a new request afterwards is granted to requester 0.
REQ-037 The bench SHALL cover: with FACT_ARB_TIMEOUT_EN and TIMEOUT=8, the model never responds -> ack after 8 WAIT cycles, res_err=1, result=0, timeout=1 sticky.
REQ-038 The bench SHALL cover: fact_done and fact_err high together -> res_err=1; a spurious fact_done while in IDLE -> no ack.
